// File: rtl/dram_write_ctrl_if.sv
// rtl/dram_write_ctrl_if.sv - AXI4 write-channel bundle between dram_write_ctrl and the DDR port
// The master modport is the controller side; the slave modport is the memory side.
interface dram_write_ctrl_if;
  logic [3:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  modport master (
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
  );

  modport slave (
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
  );
endinterface

// File: rtl/dram_write_ctrl.sv
// rtl/dram_write_ctrl.sv - buffers pipeline command/data words and issues one AXI4 INCR burst per command
// A burst is only started once all of its beats sit in the data FIFO, so W never stalls on our side.
module dram_write_ctrl #(
  parameter int         CTRL_DEPTH = 16,
  parameter int         DATA_DEPTH = 512,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [39:0]       ctrl_in,
  input  logic              ctrl_we,
  input  logic [35:0]       data_in,
  input  logic              data_we,
  output logic              ctrl_full,
  output logic              data_full,
  output logic              busy,
  output logic [31:0]       done_cnt,
  output logic              err,
  dram_write_ctrl_if.master axi
);
  localparam int CAW = $clog2(CTRL_DEPTH);
  localparam int CCW = CAW + 1;
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int DCW = DAW + 1;

  typedef enum logic [2:0] {IDLE, CHECK, ADDR, DATA, RESP} state_t;

  state_t           state_q, state_d;
  logic [CAW-1:0]   cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [CCW-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic [DAW-1:0]   dat_wp_q, dat_wp_d, dat_rp_q, dat_rp_d;
  logic [DCW-1:0]   dat_cnt_q, dat_cnt_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [7:0]       awlen_q, awlen_d;
  logic [7:0]       beat_q, beat_d;
  logic [31:0]      done_q, done_d;
  logic             err_q, err_d;

  logic [39:0]      cmd_mem [CTRL_DEPTH];
  logic [35:0]      dat_mem [DATA_DEPTH];
  logic [39:0]      cmd_head;
  logic [35:0]      dat_head;
  logic [7:0]       cmd_len;
  logic             cmd_push, cmd_pop, dat_push, dat_pop, ovf;

  assign ctrl_full = (cmd_cnt_q == CCW'(CTRL_DEPTH));
  assign data_full = (dat_cnt_q == DCW'(DATA_DEPTH));
  assign cmd_push  = ctrl_we & ~ctrl_full;
  assign dat_push  = data_we & ~data_full;
  assign ovf       = (ctrl_we & ctrl_full) | (data_we & data_full);
  assign cmd_head  = cmd_mem[cmd_rp_q];
  assign dat_head  = dat_mem[dat_rp_q];
  assign cmd_len   = cmd_head[39:32];

  always_ff @(posedge CLK) begin
    if (cmd_push) cmd_mem[cmd_wp_q] <= ctrl_in;
    if (dat_push) dat_mem[dat_wp_q] <= data_in;
  end

  always_comb begin
    cmd_wp_d  = cmd_push ? cmd_wp_q + CAW'(1) : cmd_wp_q;
    cmd_rp_d  = cmd_pop  ? cmd_rp_q + CAW'(1) : cmd_rp_q;
    dat_wp_d  = dat_push ? dat_wp_q + DAW'(1) : dat_wp_q;
    dat_rp_d  = dat_pop  ? dat_rp_q + DAW'(1) : dat_rp_q;
    cmd_cnt_d = cmd_cnt_q;
    if (cmd_push && !cmd_pop)      cmd_cnt_d = cmd_cnt_q + CCW'(1);
    else if (!cmd_push && cmd_pop) cmd_cnt_d = cmd_cnt_q - CCW'(1);
    dat_cnt_d = dat_cnt_q;
    if (dat_push && !dat_pop)      dat_cnt_d = dat_cnt_q + DCW'(1);
    else if (!dat_push && dat_pop) dat_cnt_d = dat_cnt_q - DCW'(1);
  end

  always_comb begin
    state_d  = state_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    beat_d   = beat_q;
    done_d   = done_q;
    err_d    = err_q | ovf;
    cmd_pop  = 1'b0;
    dat_pop  = 1'b0;
    case (state_q)
      IDLE: if (cmd_cnt_q != '0) state_d = CHECK;
      CHECK: begin
        if (cmd_len == 8'd0) begin
          cmd_pop = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (dat_cnt_q >= DCW'(cmd_len)) begin
          awaddr_d = cmd_head[31:0];
          awlen_d  = cmd_len - 8'd1;
          beat_d   = cmd_len;
          cmd_pop  = 1'b1;
          state_d  = ADDR;
        end
      end
      ADDR: if (axi.m_axi_awready) state_d = DATA;
      DATA: if (axi.m_axi_wready) begin
        dat_pop = 1'b1;
        beat_d  = beat_q - 8'd1;
        if (beat_q == 8'd1) state_d = RESP;
      end
      RESP: if (axi.m_axi_bvalid) begin
        done_d  = done_q + 32'd1;
        if (axi.m_axi_bresp != 2'b00) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      cmd_cnt_q <= '0;
      dat_wp_q  <= '0;
      dat_rp_q  <= '0;
      dat_cnt_q <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      beat_q    <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_wp_q  <= cmd_wp_d;
      cmd_rp_q  <= cmd_rp_d;
      cmd_cnt_q <= cmd_cnt_d;
      dat_wp_q  <= dat_wp_d;
      dat_rp_q  <= dat_rp_d;
      dat_cnt_q <= dat_cnt_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      beat_q    <= beat_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // W outputs are gated by state so stale FIFO contents never leak onto the bus (e.g. during reset).
  assign axi.m_axi_awid    = AXI_ID;
  assign axi.m_axi_awaddr  = awaddr_q;
  assign axi.m_axi_awlen   = awlen_q;
  assign axi.m_axi_awsize  = 3'b010;
  assign axi.m_axi_awburst = 2'b01;
  assign axi.m_axi_awvalid = (state_q == ADDR);
  assign axi.m_axi_wvalid  = (state_q == DATA);
  assign axi.m_axi_wdata   = (state_q == DATA) ? dat_head[31:0] : 32'd0;
  assign axi.m_axi_wstrb   = (state_q == DATA) ? dat_head[35:32] : 4'd0;
  assign axi.m_axi_wlast   = (state_q == DATA) && (beat_q == 8'd1);
  assign axi.m_axi_bready  = (state_q == RESP);
  assign busy              = (state_q != IDLE) || (cmd_cnt_q != '0);
  assign done_cnt          = done_q;
  assign err               = err_q;
endmodule

// File: tb/tb_dram_write_ctrl.sv
// tb/tb_dram_write_ctrl.sv - randomized bench for dram_write_ctrl against a queue-based burst model
// The model expects every non-zero-length command to become one burst consuming the next len pushed words.
module tb_dram_write_ctrl;
  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [39:0] ctrl_in = '0;
  logic        ctrl_we = 1'b0;
  logic [35:0] data_in = '0;
  logic        data_we = 1'b0;
  logic        ctrl_full, data_full, busy, err;
  logic [31:0] done_cnt;

  always #5 CLK = ~CLK;

  dram_write_ctrl_if axi();

  dram_write_ctrl #(.CTRL_DEPTH(16), .DATA_DEPTH(512), .AXI_ID(4'd0)) dut (
    .CLK(CLK), .RSTN(RSTN), .ctrl_in(ctrl_in), .ctrl_we(ctrl_we), .data_in(data_in),
    .data_we(data_we), .ctrl_full(ctrl_full), .data_full(data_full), .busy(busy),
    .done_cnt(done_cnt), .err(err), .axi(axi)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_addr[$];
  int          exp_len[$];
  logic [35:0] exp_data[$];
  int          exp_done;

  logic [31:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];
  logic [35:0] w_log[$];
  logic        wl_log[$];
  int          stab_err, gap_err, const_err;

  logic        stall = 1'b0;
  logic [1:0]  bresp_val = 2'b00;

  always @(posedge CLK) begin
    #1;
    axi.m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    axi.m_axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    axi.m_axi_bvalid  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    axi.m_axi_bresp   = bresp_val;
  end

  // Sampled mid-cycle: values here are exactly what the next rising edge will see.
  logic        prev_aws, prev_ws, prev_wv, prev_wend;
  logic [31:0] prev_awaddr;
  logic [7:0]  prev_awlen;
  logic [36:0] prev_w;
  always @(negedge CLK) begin
    if (!RSTN) begin
      prev_aws = 1'b0; prev_ws = 1'b0; prev_wv = 1'b0; prev_wend = 1'b0;
    end else begin
      if (prev_aws && (!axi.m_axi_awvalid || axi.m_axi_awaddr !== prev_awaddr || axi.m_axi_awlen !== prev_awlen))
        stab_err++;
      if (prev_ws && (!axi.m_axi_wvalid || {axi.m_axi_wlast, axi.m_axi_wstrb, axi.m_axi_wdata} !== prev_w))
        stab_err++;
      if (prev_wv && !prev_wend && !axi.m_axi_wvalid) gap_err++;
      if (axi.m_axi_awvalid && axi.m_axi_awready) begin
        aw_addr_log.push_back(axi.m_axi_awaddr);
        aw_len_log.push_back(axi.m_axi_awlen);
        if (axi.m_axi_awid !== 4'd0 || axi.m_axi_awsize !== 3'b010 || axi.m_axi_awburst !== 2'b01) const_err++;
      end
      if (axi.m_axi_wvalid && axi.m_axi_wready) begin
        w_log.push_back({axi.m_axi_wstrb, axi.m_axi_wdata});
        wl_log.push_back(axi.m_axi_wlast);
      end
      prev_aws    = axi.m_axi_awvalid & ~axi.m_axi_awready;
      prev_awaddr = axi.m_axi_awaddr;
      prev_awlen  = axi.m_axi_awlen;
      prev_ws     = axi.m_axi_wvalid & ~axi.m_axi_wready;
      prev_w      = {axi.m_axi_wlast, axi.m_axi_wstrb, axi.m_axi_wdata};
      prev_wv     = axi.m_axi_wvalid;
      prev_wend   = axi.m_axi_wvalid & axi.m_axi_wready & axi.m_axi_wlast;
    end
  end

  function automatic int beat_errors();
    int idx = 0;
    int e = 0;
    if (aw_addr_log.size() != exp_addr.size()) e++;
    for (int k = 0; k < exp_addr.size(); k++) begin
      if (k < aw_addr_log.size() && (aw_addr_log[k] !== exp_addr[k] || aw_len_log[k] !== 8'(exp_len[k] - 1))) e++;
      for (int b = 0; b < exp_len[k]; b++) begin
        if (idx >= w_log.size() || idx >= exp_data.size() || w_log[idx] !== exp_data[idx] ||
            wl_log[idx] !== (b == exp_len[k] - 1)) e++;
        idx++;
      end
    end
    if (w_log.size() != idx) e++;
    return e;
  endfunction

  task automatic apply_reset();
    RSTN = 1'b0; ctrl_we = 1'b0; data_we = 1'b0;
    repeat (3) @(negedge CLK);
    exp_addr.delete(); exp_len.delete(); exp_data.delete(); exp_done = 0;
    aw_addr_log.delete(); aw_len_log.delete(); w_log.delete(); wl_log.delete();
    stab_err = 0; gap_err = 0; const_err = 0;
    RSTN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [7:0] l);
    int g = 0;
    @(negedge CLK);
    while (ctrl_full && g < 5000) begin
      ctrl_we = 1'b0; data_we = 1'b0; @(negedge CLK); g++;
    end
    ctrl_in = {l, a}; ctrl_we = 1'b1; data_we = 1'b0;
    if (l != 8'd0) begin
      exp_addr.push_back(a); exp_len.push_back(int'(l)); exp_done++;
    end
  endtask

  task automatic push_data(input logic [35:0] w);
    int g = 0;
    @(negedge CLK);
    while (data_full && g < 5000) begin
      ctrl_we = 1'b0; data_we = 1'b0; @(negedge CLK); g++;
    end
    data_in = w; data_we = 1'b1; ctrl_we = 1'b0;
    exp_data.push_back(w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK); ctrl_we = 1'b0; data_we = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while ((done_cnt !== 32'(exp_done) || busy !== 1'b0) && n < budget) begin
      @(negedge CLK); n++;
    end
    tests_run++;
    if (n >= budget) begin
      tests_failed++;
      $display("FAIL %s_timeout done_cnt=%0d want %0d busy=%0b", tag, done_cnt, exp_done, busy);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    tests_run++;
    if ({busy, err, ctrl_full, data_full, axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready, axi.m_axi_wlast} !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_flags got %b want 00000000", {busy, err, ctrl_full, data_full,
               axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready, axi.m_axi_wlast});
    end
    tests_run++;
    if ({done_cnt, axi.m_axi_awaddr, axi.m_axi_awlen, axi.m_axi_wdata, axi.m_axi_wstrb} !== 108'd0) begin
      tests_failed++;
      $display("FAIL reset_values done=%0d awaddr=%h awlen=%0d wdata=%h wstrb=%h want all 0",
               done_cnt, axi.m_axi_awaddr, axi.m_axi_awlen, axi.m_axi_wdata, axi.m_axi_wstrb);
    end
    apply_reset();
  endtask

  task automatic test_single_burst();
    stall = 1'b0;
    push_cmd(32'h0000_1000, 8'd64);
    for (int i = 0; i < 64; i++) push_data({4'hF, 32'(i)});
    idle(1);
    wait_done(2000, "single");
    tests_run++;
    if (done_cnt !== 32'd1 || err !== 1'b0) begin
      tests_failed++; $display("FAIL single_status done=%0d err=%0b want 1 0", done_cnt, err);
    end
    tests_run++;
    if (aw_addr_log.size() != 1 || aw_addr_log[0] !== 32'h0000_1000 || aw_len_log[0] !== 8'd63) begin
      tests_failed++; $display("FAIL single_aw got %0d aws want one at 0x1000 len 63", aw_addr_log.size());
    end
    tests_run++;
    if (beat_errors() != 0 || const_err != 0) begin
      tests_failed++; $display("FAIL single_beats errors=%0d const=%0d want 0", beat_errors(), const_err);
    end
  endtask

  task automatic test_trickle();
    int early = 0;
    push_cmd(32'h0000_2000, 8'd64);
    for (int i = 0; i < 64; i++) begin
      push_data({4'(i), $urandom()});
      if (i < 63 && axi.m_axi_awvalid) early++;
      for (int j = 0; j < 3; j++) begin
        @(negedge CLK); ctrl_we = 1'b0; data_we = 1'b0;
        if (i < 63 && axi.m_axi_awvalid) early++;
      end
    end
    wait_done(2000, "trickle");
    tests_run++;
    if (early != 0) begin
      tests_failed++; $display("FAIL trickle_early_aw cycles=%0d want 0", early);
    end
    tests_run++;
    if (gap_err != 0 || beat_errors() != 0) begin
      tests_failed++; $display("FAIL trickle_w gaps=%0d beat_errors=%0d want 0 0", gap_err, beat_errors());
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    stall = 1'b1;
    for (int k = 0; k < 25; k++) begin
      push_cmd(32'h0010_0000 + 32'(k * 256), 8'd64);
      for (int i = 0; i < 64; i++) push_data({4'($urandom()), $urandom()});
    end
    idle(1);
    wait_done(30000, "b2b");
    stall = 1'b0;
    tests_run++;
    if (done_cnt !== 32'd25) begin
      tests_failed++; $display("FAIL b2b_done got %0d want 25", done_cnt);
    end
    tests_run++;
    if (stab_err != 0) begin
      tests_failed++; $display("FAIL b2b_stable violations=%0d want 0", stab_err);
    end
    tests_run++;
    if (gap_err != 0 || err !== 1'b0 || beat_errors() != 0) begin
      tests_failed++; $display("FAIL b2b_data gaps=%0d err=%0b beat_errors=%0d want 0 0 0", gap_err, err, beat_errors());
    end
  endtask

  task automatic test_len_zero();
    apply_reset();
    push_cmd(32'h0000_3000, 8'd0);
    push_cmd(32'h0000_3100, 8'd4);
    for (int i = 0; i < 4; i++) push_data({4'h3, $urandom()});
    idle(1);
    wait_done(1000, "len0");
    tests_run++;
    if (err !== 1'b1 || done_cnt !== 32'd1) begin
      tests_failed++; $display("FAIL len0_status err=%0b done=%0d want 1 1", err, done_cnt);
    end
    tests_run++;
    if (beat_errors() != 0) begin
      tests_failed++; $display("FAIL len0_traffic beat_errors=%0d aws=%0d want 0 1", beat_errors(), aw_addr_log.size());
    end
  endtask

  task automatic test_bresp_err();
    apply_reset();
    bresp_val = 2'b10;
    push_cmd(32'h0000_4000, 8'd8);
    for (int i = 0; i < 8; i++) push_data({4'hA, $urandom()});
    idle(1);
    wait_done(1000, "bresp1");
    bresp_val = 2'b00;
    tests_run++;
    if (err !== 1'b1 || done_cnt !== 32'd1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL bresp_status err=%0b done=%0d busy=%0b want 1 1 0", err, done_cnt, busy);
    end
    push_cmd(32'h0000_4100, 8'd2);
    push_data({4'h1, $urandom()});
    push_data({4'h2, $urandom()});
    idle(1);
    wait_done(1000, "bresp2");
    tests_run++;
    if (err !== 1'b1 || done_cnt !== 32'd2 || beat_errors() != 0) begin
      tests_failed++; $display("FAIL bresp_sticky err=%0b done=%0d beat_errors=%0d want 1 2 0", err, done_cnt, beat_errors());
    end
  endtask

  task automatic test_reset_mid_burst();
    int g = 0;
    apply_reset();
    push_cmd(32'h0000_5000, 8'd64);
    for (int i = 0; i < 64; i++) push_data({4'hC, $urandom()});
    idle(1);
    while (w_log.size() < 10 && g < 2000) begin @(negedge CLK); g++; end
    @(posedge CLK);
    #1 RSTN = 1'b0;
    #1;
    tests_run++;
    if ({axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_wlast, axi.m_axi_bready, busy, err, done_cnt, axi.m_axi_wdata, axi.m_axi_wstrb} !== 74'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs wvalid=%0b busy=%0b done=%0d wdata=%h want all 0",
               axi.m_axi_wvalid, busy, done_cnt, axi.m_axi_wdata);
    end
    apply_reset();
    push_cmd(32'h0000_6000, 8'd16);
    for (int i = 0; i < 16; i++) push_data({4'h5, $urandom()});
    idle(1);
    wait_done(1000, "midreset");
    tests_run++;
    if (done_cnt !== 32'd1 || err !== 1'b0 || beat_errors() != 0) begin
      tests_failed++; $display("FAIL midreset_fresh done=%0d err=%0b beat_errors=%0d want 1 0 0", done_cnt, err, beat_errors());
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK); ctrl_in = {8'd4, 32'(i * 256)}; ctrl_we = 1'b1;
    end
    idle(1);
    tests_run++;
    if (ctrl_full !== 1'b1 || err !== 1'b1) begin
      tests_failed++; $display("FAIL overflow ctrl_full=%0b err=%0b want 1 1", ctrl_full, err);
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_trickle();
    test_back_to_back();
    test_len_zero();
    test_bresp_err();
    test_reset_mid_burst();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
